// File: rtl/multi_hold_monitor.sv
// ----------------------------------------------------------------------------
// multi_hold_monitor: per-channel valid-holds-until-done / data-clean monitor
// with timeout, sticky errors, error pulses and a saturating clean counter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multi_hold_monitor #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   i_valid,
  input  logic [NCH-1:0]   i_done,
  input  logic [NCH-1:0]   i_data_ok,
  input  logic             i_clear,
  output logic [NCH-1:0]   o_busy,
  output logic [NCH-1:0]   o_err_drop,
  output logic [NCH-1:0]   o_err_timeout,
  output logic [NCH-1:0]   o_err_data,
  output logic [NCH-1:0]   o_err_pulse,
  output logic             o_err_any,
  output logic [CNT_W-1:0] o_clean_count
);

  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_ACTIVE   = 2'd1;
  localparam logic [1:0]       c_WAIT_LOW = 2'd2;
  localparam int               c_TW       = 8;
  localparam logic [c_TW-1:0]  c_LAST     = c_TW'(TIMEOUT - 1);
  localparam int               c_SW       = CNT_W + 6;
  localparam logic [CNT_W-1:0] c_MAX      = {CNT_W{1'b1}};

  logic [NCH-1:0] w_new_drop;
  logic [NCH-1:0] w_new_to;
  logic [NCH-1:0] w_new_data;
  logic [NCH-1:0] w_clean_done;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [1:0]      r_state, w_state_nxt;
    logic [c_TW-1:0] r_cnt, w_cnt_nxt;
    logic            r_dirty, w_dirty_nxt;
    logic [c_TW-1:0] w_cyc;
    logic            w_drop, w_to, w_data, w_clean;

    // r_cnt holds the cycle index of the previous edge; w_cyc is this edge's
    assign w_cyc = r_cnt + c_TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= c_IDLE;
        r_cnt   <= '0;
        r_dirty <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_dirty <= w_dirty_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dirty_nxt = r_dirty;
      case (r_state)
        c_IDLE: begin
          if (i_valid[g]) begin
            w_cnt_nxt   = '0;
            w_dirty_nxt = !i_data_ok[g];
            if (!i_done[g]) w_state_nxt = c_ACTIVE;
          end
        end
        c_ACTIVE: begin
          if (i_done[g]) begin
            w_state_nxt = c_IDLE;
          end else if (!i_valid[g]) begin
            w_state_nxt = c_IDLE;
          end else if (w_cyc == c_LAST) begin
            w_state_nxt = c_WAIT_LOW;
          end else begin
            w_cnt_nxt = w_cyc;
          end
          if ((i_done[g] || i_valid[g]) && !i_data_ok[g]) w_dirty_nxt = 1'b1;
        end
        c_WAIT_LOW: begin
          if (!i_valid[g]) w_state_nxt = c_IDLE;
        end
        default: w_state_nxt = c_IDLE;
      endcase
    end

    always_comb begin
      w_drop  = 1'b0;
      w_to    = 1'b0;
      w_data  = 1'b0;
      w_clean = 1'b0;
      case (r_state)
        c_IDLE: begin
          if (i_valid[g]) begin
            w_data  = !i_data_ok[g];
            w_clean = i_done[g] && i_data_ok[g];
          end
        end
        c_ACTIVE: begin
          if (i_done[g]) begin
            w_data  = !i_data_ok[g] && !r_dirty;
            w_clean = i_data_ok[g] && !r_dirty;
          end else if (!i_valid[g]) begin
            w_drop = 1'b1;
          end else begin
            w_data = !i_data_ok[g] && !r_dirty;
            w_to   = (w_cyc == c_LAST);
          end
        end
        default: ;
      endcase
    end

    assign w_new_drop[g]   = w_drop;
    assign w_new_to[g]     = w_to;
    assign w_new_data[g]   = w_data;
    assign w_clean_done[g] = w_clean;
    assign o_busy[g]       = (r_state == c_ACTIVE);
  end

  logic [NCH-1:0]   r_err_drop, r_err_to, r_err_data, r_pulse;
  logic             r_err_any;
  logic [CNT_W-1:0] r_count;
  logic [NCH-1:0]   w_drop_nxt, w_to_nxt, w_data_nxt;
  logic [c_SW-1:0]  w_pop, w_sum;
  logic [CNT_W-1:0] w_count_nxt;

  // set wins over clear on the same edge
  assign w_drop_nxt = (i_clear ? '0 : r_err_drop) | w_new_drop;
  assign w_to_nxt   = (i_clear ? '0 : r_err_to)   | w_new_to;
  assign w_data_nxt = (i_clear ? '0 : r_err_data) | w_new_data;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NCH; i++) w_pop = w_pop + c_SW'(w_clean_done[i]);
    w_sum       = (i_clear ? '0 : c_SW'(r_count)) + w_pop;
    w_count_nxt = (w_sum > c_SW'(c_MAX)) ? c_MAX : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_drop <= '0;
      r_err_to   <= '0;
      r_err_data <= '0;
      r_pulse    <= '0;
      r_err_any  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_err_drop <= w_drop_nxt;
      r_err_to   <= w_to_nxt;
      r_err_data <= w_data_nxt;
      r_pulse    <= w_new_drop | w_new_to | w_new_data;
      r_err_any  <= |{w_drop_nxt, w_to_nxt, w_data_nxt};
      r_count    <= w_count_nxt;
    end
  end

  assign o_err_drop    = r_err_drop;
  assign o_err_timeout = r_err_to;
  assign o_err_data    = r_err_data;
  assign o_err_pulse   = r_pulse;
  assign o_err_any     = r_err_any;
  assign o_clean_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_multi_hold_monitor.sv
// ----------------------------------------------------------------------------
// tb_multi_hold_monitor: table-driven scoreboard bench for multi_hold_monitor.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multi_hold_monitor;

  typedef struct {
    logic [3:0] v, d, ok;
    logic       clr;
    logic [3:0] busy, edrop, eto, edat, pulse;
    logic       any;
    logic [7:0] cnt;
    logic       c3en;
    logic [2:0] cnt3;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] valid = '0, done = '0, data_ok = 4'hF;
  logic       clear = 1'b0;
  logic [3:0] busy, edrop, eto, edat, pulse;
  logic       any;
  logic [7:0] cnt;
  logic [3:0] b3, ed3, et3, eda3, p3;
  logic       any3;
  logic [2:0] cnt3;

  int n_assert = 0;
  int n_fail   = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  multi_hold_monitor #(.NCH(4), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_done(done), .i_data_ok(data_ok),
    .i_clear(clear), .o_busy(busy), .o_err_drop(edrop), .o_err_timeout(eto),
    .o_err_data(edat), .o_err_pulse(pulse), .o_err_any(any), .o_clean_count(cnt)
  );

  multi_hold_monitor #(.NCH(4), .TIMEOUT(16), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_done(done), .i_data_ok(data_ok),
    .i_clear(clear), .o_busy(b3), .o_err_drop(ed3), .o_err_timeout(et3),
    .o_err_data(eda3), .o_err_pulse(p3), .o_err_any(any3), .o_clean_count(cnt3)
  );

  function automatic vec_t V(logic [3:0] v, d, ok, logic clr, logic [3:0] bsy, edr, eto_e,
                             eda, pls, logic an, logic [7:0] c, logic c3e = 1'b0,
                             logic [2:0] c3 = 3'd0);
    vec_t t;
    t.v = v; t.d = d; t.ok = ok; t.clr = clr;
    t.busy = bsy; t.edrop = edr; t.eto = eto_e; t.edat = eda; t.pulse = pls;
    t.any = an; t.cnt = c; t.c3en = c3e; t.cnt3 = c3;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_assert++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  task automatic compare(input vec_t e);
    chk("busy", 32'(busy), 32'(e.busy));
    chk("err_drop", 32'(edrop), 32'(e.edrop));
    chk("err_timeout", 32'(eto), 32'(e.eto));
    chk("err_data", 32'(edat), 32'(e.edat));
    chk("err_pulse", 32'(pulse), 32'(e.pulse));
    chk("err_any", 32'(any), 32'(e.any));
    chk("clean_count", 32'(cnt), 32'(e.cnt));
    if (e.c3en) chk("clean_count_w3", 32'(cnt3), 32'(e.cnt3));
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    valid = t.v; done = t.d; data_ok = t.ok; clear = t.clr;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++; n_fail++;
      $display("FAIL scoreboard_empty @%0t", $time);
    end else begin
      compare(exp_q.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // clean hold on ch0, then a done with no valid
    for (int i = 0; i < 4; i++) tbl.push_back(V(1, 0, 4'hF, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(V(0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1));
    // drop on ch1
    for (int i = 0; i < 3; i++) tbl.push_back(V(2, 0, 4'hF, 0, 2, 0, 0, 0, 0, 0, 1));
    tbl.push_back(V(0, 0, 4'hF, 0, 0, 2, 0, 0, 2, 1, 1));
    tbl.push_back(V(0, 0, 4'hF, 0, 0, 2, 0, 0, 0, 1, 1));
    // ch2: last legal done at cycle 15
    for (int i = 0; i < 15; i++) tbl.push_back(V(4, 0, 4'hF, 0, 4, 2, 0, 0, 0, 1, 1));
    tbl.push_back(V(4, 4, 4'hF, 0, 0, 2, 0, 0, 0, 1, 2));
    tbl.push_back(V(0, 0, 4'hF, 0, 0, 2, 0, 0, 0, 1, 2));
    // ch2: timeout at cycle 15, stuck valid, ignored done, restart
    for (int i = 0; i < 15; i++) tbl.push_back(V(4, 0, 4'hF, 0, 4, 2, 0, 0, 0, 1, 2));
    tbl.push_back(V(4, 0, 4'hF, 0, 0, 2, 4, 0, 4, 1, 2));
    for (int i = 16; i < 20; i++) tbl.push_back(V(4, 0, 4'hF, 0, 0, 2, 4, 0, 0, 1, 2));
    tbl.push_back(V(4, 4, 4'hF, 0, 0, 2, 4, 0, 0, 1, 2));
    tbl.push_back(V(0, 0, 4'hF, 0, 0, 2, 4, 0, 0, 1, 2));
    tbl.push_back(V(4, 0, 4'hF, 0, 4, 2, 4, 0, 0, 1, 2));
    tbl.push_back(V(4, 4, 4'hF, 0, 0, 2, 4, 0, 0, 1, 3));
    // ch3 data fault on done cycle
    tbl.push_back(V(8, 0, 4'hF, 0, 8, 2, 4, 0, 0, 1, 3));
    tbl.push_back(V(8, 8, 4'h7, 0, 0, 2, 4, 8, 8, 1, 3));
    tbl.push_back(V(0, 0, 4'hF, 0, 0, 2, 4, 8, 0, 1, 3));
    // clear together with a new ch0 drop, then re-triggered drop
    tbl.push_back(V(1, 0, 4'hF, 0, 1, 2, 4, 8, 0, 1, 3));
    tbl.push_back(V(0, 0, 4'hF, 1, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(V(0, 0, 4'hF, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(V(1, 0, 4'hF, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(V(0, 0, 4'hF, 0, 0, 1, 0, 0, 1, 1, 0));
    // clear together with a clean completion
    tbl.push_back(V(1, 1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 1));
    // back-to-back on ch1
    tbl.push_back(V(2, 0, 4'hF, 0, 2, 0, 0, 0, 0, 0, 1));
    tbl.push_back(V(2, 2, 4'hF, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(V(2, 0, 4'hF, 0, 2, 0, 0, 0, 0, 0, 2));
    tbl.push_back(V(2, 2, 4'hF, 0, 0, 0, 0, 0, 0, 0, 3));
    // data fault at cycle 0 of a single-cycle transaction
    tbl.push_back(V(4, 4, 4'hB, 0, 0, 0, 0, 4, 4, 1, 3));
    tbl.push_back(V(0, 0, 4'hF, 0, 0, 0, 0, 4, 0, 1, 3));
    // saturation with concurrent completions
    tbl.push_back(V(0, 0, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(4'hF, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 4, 1, 4));
    tbl.push_back(V(4'hF, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 8, 1, 7));
    tbl.push_back(V(4'hF, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 12, 1, 7));
    // leave an error and a live ch0 transaction before reset
    tbl.push_back(V(2, 0, 4'hF, 0, 2, 0, 0, 0, 0, 0, 12));
    tbl.push_back(V(0, 0, 4'hF, 0, 0, 2, 0, 0, 2, 1, 12));
    tbl.push_back(V(1, 0, 4'hF, 0, 1, 2, 0, 0, 0, 1, 12));
    tbl.push_back(V(1, 0, 4'hF, 0, 1, 2, 0, 0, 0, 1, 12));

    repeat (2) @(posedge clk);
    #1;
    compare(V(0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // async reset in cycle 2 of the active ch0 transaction
    @(negedge clk);
    valid = 4'h1; done = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    compare(V(0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk);
    @(negedge clk);
    valid = 4'h0;
    rst_n = 1'b1;
    step(V(1, 0, 4'hF, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    step(V(1, 1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    step(V(0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_hold_monitor.md
Name: multi_hold_monitor

Overview:
- Synthesizable, parametrised protocol monitor: runtime hardware counterpart of the valid-holds-until-done and data-clean-through-done checks.
- Tracks NCH independent valid/done/data_ok channels, each with its own FSM.
- Adds a bounded-liveness timeout, per-channel sticky error flags, one-cycle error pulses and a saturating clean-transaction counter.
- Sits beside a DUT interface in simulation or emulation; it drives no DUT signals.

Parameters:
- NCH, 4, number of monitored channels (1..32).
- TIMEOUT, 16, done must arrive by cycle TIMEOUT after the start cycle (2..255).
- CNT_W, 8, width of the clean-transaction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  NCH  per-channel request-valid.
- done  in  NCH  per-channel completion strobe.
- data_ok  in  NCH  per-channel data-integrity indication.
- clear  in  1  synchronous clear of sticky errors and counter.
- busy  out  NCH  channel is in ACTIVE.
- err_drop  out  NCH  sticky: valid fell before done.
- err_timeout  out  NCH  sticky: no done by cycle TIMEOUT.
- err_data  out  NCH  sticky: data_ok low during a transaction.
- err_pulse  out  NCH  one-cycle pulse on any new error for that channel.
- err_any  out  1  OR of all sticky error bits.
- clean_count  out  CNT_W  saturating count of error-free completed transactions.

Behaviour:
- Reset (async, rst_n=0): every channel goes to IDLE, wait counters 0, all outputs 0. This also applies mid-transaction, and the aborted transaction is not counted.
- All outputs are registered. A condition sampled at edge k is visible from edge k onward, until the next edge.
- Per-channel FSM states: IDLE, ACTIVE, WAIT_LOW.
- IDLE:
  - valid=1 starts a transaction ("cycle 0"), wait counter=0, and data_ok is checked.
  - valid=1 & done=1 in the same cycle: single-cycle transaction, complete, stays IDLE.
  - valid=1 & done=0: go to ACTIVE.
  - done with valid=0: ignored.
- ACTIVE, evaluated each edge in this priority order:
  - done=1: complete. valid is not required on the done cycle (strong-until semantics). Go to IDLE.
  - valid=0: drop error, go to IDLE.
  - counter==TIMEOUT-1: timeout error, go to WAIT_LOW.
  - Otherwise: counter++.
- Timeout timing: the last legal done is at cycle TIMEOUT-1 relative to start; the timeout is flagged at cycle TIMEOUT-1's edge if done is still absent there. busy=1 exactly while in ACTIVE.
- WAIT_LOW: done is ignored; valid=0 returns the channel to IDLE. This prevents a stuck valid from re-triggering a transaction.
- data_ok check:
  - Applies on every cycle from cycle 0 through the completing cycle, inclusive.
  - data_ok=0 on any of these cycles sets err_data once per transaction and marks the transaction dirty.
  - A data error does not abort the transaction.
- Completion counting:
  - A completion that is not dirty increments clean_count.
  - When several channels complete cleanly in the same cycle, clean_count adds their popcount.
  - clean_count saturates at 2^CNT_W-1; it never wraps.
- Back-to-back: after completing in ACTIVE, valid=1 on the next cycle starts a new transaction from IDLE without a gap.
- Sticky errors and clear:
  - Each sticky bit is set on its error and held until clear=1.
  - If clear and a new error occur in the same cycle, the new error is set (set wins) and older bits clear.
  - If clear and a clean completion occur in the same cycle, clean_count becomes the number of completions that cycle.
- err_pulse[i] is high for exactly one cycle whenever any err_* bit of channel i is newly triggered, even if that bit was already set.
- Channels are fully independent. There is no cross-channel interaction except through clean_count and err_any.

Test Plan:
- Clean hold (NCH=4, TIMEOUT=16): ch0 valid high cycles 0-4, done at cycle 4, data_ok=1 throughout -> busy[0] high cycles 1-4, clean_count 0->1, no errors.
- Drop: ch1 valid high at cycle 0, low at cycle 3, done never -> err_drop[1]=1 with a one-cycle err_pulse[1], channel back in IDLE, clean_count unchanged, err_any=1.
- Timeout boundary: ch2 done at cycle 15 -> clean completion. Repeat with valid held high and no done -> err_timeout[2] at cycle 15's edge, then WAIT_LOW; done at cycle 20 is ignored; valid low then high restarts a transaction.
- Data fault plus same-cycle events: ch3 data_ok=0 only on the done cycle -> err_data[3]=1 and no count. Then clear in the same cycle as a new ch0 drop -> err_drop[0]=1 and all other sticky bits 0.
- Saturation and concurrency: CNT_W=3, repeated clean single-cycle transactions on all 4 channels simultaneously -> count steps 0,4,7,7.
- Async reset mid-transaction: rst_n low in cycle 2 of an active ch0 transaction -> busy, all errors and clean_count 0 immediately; next valid starts fresh.
